// File: rtl/mem_arbiter.sv
// Purpose: share one single-port synchronous memory between an instruction-fetch port and a data port.
// Latency: grant is combinational in the request cycle; rvalid/rdata follow exactly one cycle later.
// Backpressure: requesters hold req/addr/we/wdata until gnt; data wins unless a fetch has waited MAX_DATA_STREAK grants.
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4    // legal range 1..15, must fit the 4-bit streak counter
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Owner of the access issued last cycle; decides which port the memory word belongs to.
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2,
        OWN_STORE = 2'd3
    } owner_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    logic [3:0] streak;
    owner_t     owner;
    logic       fetch_wins;

    // Arbitration: data first, except a waiting fetch that has sat through STREAK_MAX data grants.
    // Everything is forced quiet while reset is high so no access escapes during reset.
    always_comb begin
        fetch_wins = i_req && (!d_req || (streak == STREAK_MAX));
        i_gnt      = !reset && fetch_wins;
        d_gnt      = !reset && d_req && !fetch_wins;
        mem_en     = i_gnt || d_gnt;
        mem_we     = d_gnt && d_we;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (i_gnt) begin
            mem_addr = i_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end
    end

    // Response steering: route the memory word to last cycle's owner, zero otherwise.
    // Reset gates the responses so an access granted just before reset never completes.
    always_comb begin
        i_rvalid = !reset && (owner == OWN_FETCH);
        d_rvalid = !reset && ((owner == OWN_LOAD) || (owner == OWN_STORE));
        i_rdata  = i_rvalid ? mem_rdata : '0;
        d_rdata  = (!reset && (owner == OWN_LOAD)) ? mem_rdata : '0;
    end

    // Streak counter: counts data grants that overtook a waiting fetch, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (!i_req || i_gnt) begin
            streak <= '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 4'd1;
        end
    end

    // One-entry response tracker: remembers who owns the access issued this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= OWN_NONE;
        end else if (i_gnt) begin
            owner <= OWN_FETCH;
        end else if (d_gnt) begin
            owner <= d_we ? OWN_STORE : OWN_LOAD;
        end else begin
            owner <= OWN_NONE;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port synchronous memory.
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
// Memory word k is preset to 0xA000_0000 + k while reset is high.
module tb_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic [DW-1:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .MAX_DATA_STREAK(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory, preset with a known pattern during reset.
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hA000_0000 + 32'(k);
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr[AW-1:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[AW-1:2]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1 ({tag, ".i_gnt"},    i_gnt,    1'b0);
        chk1 ({tag, ".d_gnt"},    d_gnt,    1'b0);
        chk1 ({tag, ".i_rvalid"}, i_rvalid, 1'b0);
        chk1 ({tag, ".d_rvalid"}, d_rvalid, 1'b0);
        chk1 ({tag, ".mem_en"},   mem_en,   1'b0);
        chk1 ({tag, ".mem_we"},   mem_we,   1'b0);
        chk32({tag, ".mem_addr"}, 32'(mem_addr), 32'h0);
        chk32({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        chk32({tag, ".i_rdata"},  i_rdata,  32'h0);
        chk32({tag, ".d_rdata"},  d_rdata,  32'h0);
    endtask

    logic [9:0] fetch_turn;

    initial begin
        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        tick;
        // Requests present during reset must be ignored.
        i_req   = 1'b1;
        i_addr  = 10'h004;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h010;
        d_wdata = 32'h1234_5678;
        #1 chk_quiet("reset");
        tick;
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
        tick;

        // Fetch only.
        reset  = 1'b0;
        i_req  = 1'b1;
        i_addr = 10'h004;
        #1;
        chk1 ("fetch.i_gnt",    i_gnt,  1'b1);
        chk1 ("fetch.d_gnt",    d_gnt,  1'b0);
        chk1 ("fetch.mem_en",   mem_en, 1'b1);
        chk1 ("fetch.mem_we",   mem_we, 1'b0);
        chk32("fetch.mem_addr", 32'(mem_addr), 32'h004);
        tick;
        i_req = 1'b0;
        chk1 ("fetch.i_rvalid", i_rvalid, 1'b1);
        chk32("fetch.i_rdata",  i_rdata,  32'hA000_0001);
        chk1 ("fetch.d_rvalid", d_rvalid, 1'b0);
        #1 chk1("fetch.idle_en", mem_en, 1'b0);
        tick;
        chk1 ("fetch.after_rvalid", i_rvalid, 1'b0);
        chk32("fetch.after_rdata",  i_rdata,  32'h0);

        // Back-to-back fetches with no bubble.
        i_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_addr = 10'(4 * k);
            #1;
            chk1 ($sformatf("b2b%0d.i_gnt", k), i_gnt, 1'b1);
            chk32($sformatf("b2b%0d.mem_addr", k), 32'(mem_addr), 32'(4 * k));
            tick;
            chk1 ($sformatf("b2b%0d.i_rvalid", k), i_rvalid, 1'b1);
            chk32($sformatf("b2b%0d.i_rdata", k), i_rdata, 32'hA000_0000 + 32'(k));
        end
        i_req = 1'b0;
        tick;
        chk1("b2b.end_rvalid", i_rvalid, 1'b0);

        // Contention: data load wins, fetch follows once data drops.
        i_req  = 1'b1;
        i_addr = 10'h020;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 10'h100;
        #1;
        chk1 ("cont.d_gnt",    d_gnt, 1'b1);
        chk1 ("cont.i_gnt",    i_gnt, 1'b0);
        chk32("cont.mem_addr", 32'(mem_addr), 32'h100);
        tick;
        d_req = 1'b0;
        chk1 ("cont.d_rvalid", d_rvalid, 1'b1);
        chk32("cont.d_rdata",  d_rdata,  32'hA000_0040);
        chk1 ("cont.i_rvalid", i_rvalid, 1'b0);
        #1;
        chk1 ("cont.i_gnt2",    i_gnt, 1'b1);
        chk32("cont.mem_addr2", 32'(mem_addr), 32'h020);
        tick;
        i_req = 1'b0;
        chk1 ("cont.i_rvalid2", i_rvalid, 1'b1);
        chk32("cont.i_rdata2",  i_rdata,  32'hA000_0008);
        chk1 ("cont.d_rvalid2", d_rvalid, 1'b0);
        tick;

        // Store then load back.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 10'h010;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        chk1 ("st.d_gnt",     d_gnt,  1'b1);
        chk1 ("st.mem_we",    mem_we, 1'b1);
        chk32("st.mem_addr",  32'(mem_addr), 32'h010);
        chk32("st.mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        tick;
        d_we = 1'b0;
        chk1("st.d_rvalid", d_rvalid, 1'b1);
        chk1("st.i_rvalid", i_rvalid, 1'b0);
        #1;
        chk1("ld.d_gnt",  d_gnt,  1'b1);
        chk1("ld.mem_we", mem_we, 1'b0);
        tick;
        d_req = 1'b0;
        chk1 ("ld.d_rvalid", d_rvalid, 1'b1);
        chk32("ld.d_rdata",  d_rdata,  32'hDEAD_BEEF);
        tick;
        chk1 ("ld.end_rvalid", d_rvalid, 1'b0);
        chk32("ld.end_rdata",  d_rdata,  32'h0);

        // Starvation guard: fetch gets every fifth slot under continuous data pressure.
        fetch_turn = 10'b10000_10000;
        i_req  = 1'b1;
        i_addr = 10'h00C;
        d_req  = 1'b1;
        d_we   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            d_addr = 10'h200 + 10'(4 * c);
            #1;
            chk1($sformatf("starve%0d.i_gnt", c), i_gnt, fetch_turn[c]);
            chk1($sformatf("starve%0d.d_gnt", c), d_gnt, !fetch_turn[c]);
            tick;
            if (fetch_turn[c]) begin
                chk1 ($sformatf("starve%0d.i_rvalid", c), i_rvalid, 1'b1);
                chk32($sformatf("starve%0d.i_rdata", c), i_rdata, 32'hA000_0003);
            end else begin
                chk1 ($sformatf("starve%0d.d_rvalid", c), d_rvalid, 1'b1);
                chk32($sformatf("starve%0d.d_rdata", c), d_rdata, 32'hA000_0080 + 32'(c));
            end
            chk1($sformatf("starve%0d.excl", c), i_rvalid && d_rvalid, 1'b0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        tick;

        // Reset right after a load grant: the load never completes; pending fetch wins on release.
        d_req  = 1'b1;
        d_addr = 10'h100;
        #1 chk1("rst.d_gnt", d_gnt, 1'b1);
        tick;
        d_req  = 1'b0;
        reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 10'h004;
        #1 chk_quiet("rst.mid");
        tick;
        chk_quiet("rst.hold");
        reset = 1'b0;
        #1;
        chk1 ("rst.rel_i_gnt",    i_gnt, 1'b1);
        chk32("rst.rel_mem_addr", 32'(mem_addr), 32'h004);
        chk1 ("rst.rel_d_rvalid", d_rvalid, 1'b0);
        tick;
        i_req = 1'b0;
        chk1 ("rst.i_rvalid", i_rvalid, 1'b1);
        chk32("rst.i_rdata",  i_rdata,  32'hA000_0001);
        chk1 ("rst.d_rvalid", d_rvalid, 1'b0);
        tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
